ctrl_sequencer: RTL and testbench

Synthesizable, parametrised instruction sequencer for the 8-bit processor. It fetches 16-bit instructions from an external instruction memory over a valid/request handshake, decodes them, and executes them against an internal register file and add/sub ALU. It extends the existing instruction set with JZ, a zero flag, memory wait states, illegal-opcode trapping, restart-from-halt, and a debug register read port. Data width and register count are generic.

---
 rtl/ctrl_sequencer.sv | 155 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer: fetches 16-bit words over a valid/request handshake and
// executes them against a small register file with an add/sub ALU.
module ctrl_sequencer #(
  parameter int DW  = 8,
  parameter int RA  = 2,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [15:0]    imem_rdata,
  output logic           busy,
  output logic           halted,
  output logic           trap,
  output logic           retire,
  output logic           zflag,
  output logic [PCW-1:0] pc,
  input  logic [RA-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  localparam int NREG = 1 << RA;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JNZ = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PCW-1:0]  r_pc;
  logic [15:0]     r_ir;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_zflag;
  logic            r_trap;

  logic [3:0]      w_op;
  logic [RA-1:0]   w_rd;
  logic [RA-1:0]   w_rs1;
  logic [RA-1:0]   w_rs2;
  logic [DW-1:0]   w_imm;
  logic [PCW-1:0]  w_tgt;
  logic [DW-1:0]   w_rd_val;
  logic [DW-1:0]   w_rs1_val;
  logic [DW-1:0]   w_rs2_val;
  logic [DW-1:0]   w_result;
  logic [PCW-1:0]  w_pc_inc;
  logic [PCW-1:0]  w_pc_next;
  logic            w_wr_en;
  logic            w_halt;
  logic            w_illegal;
  logic            w_unused_ir;

  assign w_op      = r_ir[15:12];
  assign w_rd      = r_ir[8 +: RA];
  assign w_rs1     = r_ir[4 +: RA];
  assign w_rs2     = r_ir[0 +: RA];
  assign w_imm     = DW'(r_ir[7:0]);
  assign w_tgt     = r_ir[PCW-1:0];
  assign w_rd_val  = r_regs[w_rd];
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];
  assign w_pc_inc  = r_pc + PCW'(1);
  // Instruction bits not decoded for narrow RA/PCW settings.
  assign w_unused_ir = ^r_ir;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_wr_en   = 1'b0;
    w_result  = '0;
    w_pc_next = w_pc_inc;
    w_halt    = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_ADD: begin w_wr_en = 1'b1; w_result = w_rs1_val + w_rs2_val; end
      OP_SUB: begin w_wr_en = 1'b1; w_result = w_rs1_val - w_rs2_val; end
      OP_LDI: begin w_wr_en = 1'b1; w_result = w_imm; end
      OP_INC: begin w_wr_en = 1'b1; w_result = w_rd_val + DW'(1); end
      OP_DEC: begin w_wr_en = 1'b1; w_result = w_rd_val - DW'(1); end
      OP_HLT: begin w_halt = 1'b1; w_pc_next = r_pc; end
      OP_JZ:  if (w_rd_val == '0) w_pc_next = w_tgt;
      OP_JNZ: if (w_rd_val != '0) w_pc_next = w_tgt;
      OP_JMP: w_pc_next = w_tgt;
      default: begin
        w_halt    = 1'b1;
        w_illegal = 1'b1;
        w_pc_next = r_pc;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_state_next = S_FETCH;
      S_FETCH:        if (imem_valid) w_state_next = S_EXEC;
      S_EXEC:         w_state_next = w_halt ? S_HALT : S_FETCH;
      default:        w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the register file is reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_zflag <= 1'b0;
      r_trap  <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc   <= '0;
            r_trap <= 1'b0;
          end
        end
        S_FETCH: if (imem_valid) r_ir <= imem_rdata;
        S_EXEC: begin
          r_pc <= w_pc_next;
          if (w_wr_en) begin
            r_regs[w_rd] <= w_result;
            r_zflag      <= (w_result == '0);
          end
          if (w_illegal) r_trap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign halted    = (r_state == S_HALT);
  assign retire    = (r_state == S_EXEC);
  assign trap      = r_trap;
  assign zflag     = r_zflag;
  assign pc        = r_pc;
  assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: an instruction-level model checked every cycle,
// plus directed programs with hand-computed results.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        busy, halted, trap, retire, zflag;
  logic [7:0]  pc;
  logic [1:0]  dbg_addr = 2'd0;
  logic [7:0]  dbg_data;

  ctrl_sequencer #(.DW(8), .RA(2), .PCW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .busy(busy), .halted(halted), .trap(trap), .retire(retire),
    .zflag(zflag), .pc(pc), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  logic [15:0] prog [256];
  int          waits = 0;
  bit          late_valid = 1'b0;
  int          n_cmp = 0, n_err = 0, n_retire = 0, n_busy = 0;

  // Instruction-level model of the processor.
  logic [7:0]  m_regs [4] = '{default: 8'h00};
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  bit          m_z = 1'b0, m_trap = 1'b0, m_halted = 1'b0;
  bit          m_running = 1'b0, m_exec = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_exec();
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic [7:0] res;
    bit         wr;
    op  = m_ir[15:12];
    rd  = m_ir[9:8];
    ra  = m_ir[5:4];
    rb  = m_ir[1:0];
    res = 8'h00;
    wr  = 1'b0;
    case (op)
      4'h0: begin res = m_regs[ra] + m_regs[rb]; wr = 1'b1; end
      4'h1: begin res = m_regs[ra] - m_regs[rb]; wr = 1'b1; end
      4'h8: begin res = m_ir[7:0]; wr = 1'b1; end
      4'hA: begin res = m_regs[rd] + 8'd1; wr = 1'b1; end
      4'hB: begin res = m_regs[rd] - 8'd1; wr = 1'b1; end
      4'hC: begin m_halted = 1'b1; m_running = 1'b0; end
      4'hD: m_pc = (m_regs[rd] == 8'h00) ? m_ir[7:0] : m_pc + 8'd1;
      4'hE: m_pc = (m_regs[rd] != 8'h00) ? m_ir[7:0] : m_pc + 8'd1;
      4'hF: m_pc = m_ir[7:0];
      default: begin m_halted = 1'b1; m_running = 1'b0; m_trap = 1'b1; end
    endcase
    if (wr) begin
      m_regs[rd] = res;
      m_z        = (res == 8'h00);
      m_pc       = m_pc + 8'd1;
    end
    m_exec = 1'b0;
  endtask

  // Compare every cycle, then advance the model with the inputs the next edge will see.
  initial forever begin
    @(negedge clk);
    check("imem_req", 32'(imem_req), 32'(m_running && !m_exec));
    if (m_running && !m_exec) check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("busy",     32'(busy),     32'(m_running));
    check("halted",   32'(halted),   32'(m_halted));
    check("trap",     32'(trap),     32'(m_trap));
    check("retire",   32'(retire),   32'(m_exec));
    check("zflag",    32'(zflag),    32'(m_z));
    check("pc",       32'(pc),       32'(m_pc));
    check("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
    n_retire += int'(retire);
    n_busy   += int'(busy);
    if (rst) begin
      m_regs = '{default: 8'h00};
      m_pc = 8'h00; m_ir = 16'h0000;
      m_z = 1'b0; m_trap = 1'b0; m_halted = 1'b0; m_running = 1'b0; m_exec = 1'b0;
    end else if (m_exec) begin
      model_exec();
    end else if (m_running) begin
      if (imem_valid) begin
        m_ir   = imem_rdata;
        m_exec = 1'b1;
      end
    end else if (start) begin
      m_running = 1'b1; m_pc = 8'h00; m_trap = 1'b0; m_halted = 1'b0;
    end
  end

  // Instruction memory with a configurable number of wait cycles per fetch.
  initial begin
    int w_cnt;
    w_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        if (w_cnt < waits) begin
          imem_valid = 1'b0;
          w_cnt++;
        end else begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr];
          w_cnt      = 0;
        end
      end else begin
        w_cnt      = 0;
        imem_valid = late_valid;
        imem_rdata = 16'h8FFF;
      end
    end
  end

  // Sweep the debug port so the model sees every register.
  initial forever begin
    @(posedge clk); #1;
    dbg_addr = dbg_addr + 2'd1;
  end

  task automatic load4(input logic [15:0] a, b, c, d);
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    @(posedge clk); #2;
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
    @(negedge clk);
    for (int i = 0; i < 8 && dbg_addr != r; i++) @(negedge clk);
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int rb, bb;
    for (int i = 0; i < 256; i++) prog[i] = 16'hC000;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check_reg("rst_r2", 2'd2, 8'h00);

    // LDI/LDI/ADD/HLT
    load4(16'h8005, 16'h8103, 16'h0201, 16'hC000);
    rb = n_retire; bb = n_busy;
    pulse_start();
    wait_halted(100);
    check_reg("add_r2", 2'd2, 8'h08);
    check("add_zflag", 32'(zflag), 32'd0);
    check("add_pc", 32'(pc), 32'd3);
    check("add_retires", 32'(n_retire - rb), 32'd4);
    check("add_busy_cycles", 32'(n_busy - bb), 32'd8);

    // SUB going negative, then SUB of a register with itself
    load4(16'h8003, 16'h8105, 16'h1201, 16'hC000);
    pulse_start();
    wait_halted(100);
    check_reg("sub_r2", 2'd2, 8'hFE);
    check("sub_zflag", 32'(zflag), 32'd0);
    load4(16'h1300, 16'hC000, 16'hC000, 16'hC000);
    pulse_start();
    wait_halted(100);
    check_reg("subself_r3", 2'd3, 8'h00);
    check("subself_zflag", 32'(zflag), 32'd1);
    check("subself_pc", 32'(pc), 32'd1);

    // DEC/JNZ loop, without and with wait states
    for (int w = 0; w <= 3; w += 3) begin
      waits = w;
      load4(16'h8003, 16'hB000, 16'hE001, 16'hC000);
      rb = n_retire; bb = n_busy;
      pulse_start();
      wait_halted(200);
      check_reg("loop_r0", 2'd0, 8'h00);
      check("loop_zflag", 32'(zflag), 32'd1);
      check("loop_pc", 32'(pc), 32'd3);
      check("loop_retires", 32'(n_retire - rb), 32'd8);
      check("loop_busy_cycles", 32'(n_busy - bb), (w == 0) ? 32'd16 : 32'd40);
    end
    waits = 0;

    // Illegal opcode traps, then restart clears the trap
    prog[0] = 16'h2000;
    rb = n_retire;
    pulse_start();
    wait_halted(100);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_pc", 32'(pc), 32'd0);
    check("ill_retires", 32'(n_retire - rb), 32'd1);
    check_reg("ill_r1", 2'd1, 8'h05);
    pulse_start();
    check("restart_trap", 32'(trap), 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    wait_halted(100);
    check("reill_trap", 32'(trap), 32'd1);

    // JZ taken skips an LDI r3 in the fall-through path
    load4(16'h8000, 16'hD005, 16'h8FFF, 16'hC000);
    prog[5] = 16'hC000;
    rb = n_retire;
    pulse_start();
    wait_halted(100);
    check("jz_pc", 32'(pc), 32'd5);
    check("jz_zflag", 32'(zflag), 32'd1);
    check("jz_retires", 32'(n_retire - rb), 32'd3);
    check_reg("jz_r3", 2'd3, 8'h00);

    // JMP to 0xFF, INC wraps pc to 0, reset lands mid-fetch
    waits = 6;
    prog[0]   = 16'hF0FF;
    prog[255] = 16'hA300;
    rb = n_retire;
    pulse_start();
    for (int i = 0; i < 60 && n_retire < rb + 2; i++) begin
      @(posedge clk); #2;
    end
    check("jmp_retires", 32'(n_retire - rb), 32'd2);
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", 32'(imem_addr), 32'd0);
    check_reg("inc_r3", 2'd3, 8'h01);
    @(posedge clk); #2; rst = 1'b1; late_valid = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_pc", 32'(pc), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_halted", 32'(halted), 32'd0);
    check("post_rst_retire", 32'(retire), 32'd0);
    check_reg("post_rst_r3", 2'd3, 8'h00);
    check_reg("post_rst_r1", 2'd1, 8'h00);
    late_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
